// File: rtl/cond_unit_mt_if.sv
// Execute-stage condition/flag bus for cond_unit_mt: instruction, flag-write and
// predicated-block request signals in, execute decision and committed flags out.
interface cond_unit_mt_if #(
    parameter int NCTX  = 2,
    parameter int MAXIT = 4
);
    localparam int CTXW = (NCTX > 1) ? $clog2(NCTX) : 1;
    localparam int LENW = $clog2(MAXIT + 1);

    logic            valid_e;
    logic            stall_e;
    logic            flush_e;
    logic [CTXW-1:0] ctx_e;
    logic [3:0]      cond_e;
    logic [3:0]      alu_flags;
    logic [1:0]      flag_write_e;
    logic            it_start;
    logic [CTXW-1:0] it_ctx;
    logic [3:0]      it_cond;
    logic [LENW-1:0] it_len;
    logic [MAXIT-1:0] it_then;
    logic            cond_ex;
    logic [3:0]      flags_e;
    logic            it_active;
    logic            undef_cond;

    modport master (
        output valid_e, stall_e, flush_e, ctx_e, cond_e, alu_flags, flag_write_e,
        output it_start, it_ctx, it_cond, it_len, it_then,
        input  cond_ex, flags_e, it_active, undef_cond
    );

    modport slave (
        input  valid_e, stall_e, flush_e, ctx_e, cond_e, alu_flags, flag_write_e,
        input  it_start, it_ctx, it_cond, it_len, it_then,
        output cond_ex, flags_e, it_active, undef_cond
    );
endinterface

// File: rtl/cond_unit_mt.sv
// Multi-context ARM condition unit: per-context NZCV registers, combinational
// condition check and an IT-style predicated-block sequencer.
module cond_unit_mt #(
    parameter int NCTX  = 2,
    parameter int MAXIT = 4
) (
    input logic             clk,
    input logic             reset,
    cond_unit_mt_if.slave   bus
);
    localparam int CTXW  = (NCTX > 1) ? $clog2(NCTX) : 1;
    localparam int LENW  = $clog2(MAXIT + 1);
    localparam int NSLOT = 2 ** LENW;
    localparam int NREG  = 2 ** CTXW;
    localparam logic [LENW-1:0] LEN_ONE = 1;

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t           state_q;
    logic [CTXW-1:0]  blk_ctx_q;
    logic [3:0]       blk_cond_q;
    logic [NSLOT-1:0] blk_then_q;
    logic [LENW-1:0]  blk_len_q;
    logic [LENW-1:0]  slot_q;
    logic [3:0]       flags_q [NREG];

    logic       ctx_ok;
    logic       in_blk;
    logic       live;
    logic       commit;
    logic       consume;
    logic       len_ok;
    logic [3:0] cur_flags;
    logic [3:0] slot_cond;
    logic [3:0] eff_cond;

    function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'b0000: cond_pass = z;
            4'b0001: cond_pass = ~z;
            4'b0010: cond_pass = cy;
            4'b0011: cond_pass = ~cy;
            4'b0100: cond_pass = n;
            4'b0101: cond_pass = ~n;
            4'b0110: cond_pass = v;
            4'b0111: cond_pass = ~v;
            4'b1000: cond_pass = cy & ~z;
            4'b1001: cond_pass = ~cy | z;
            4'b1010: cond_pass = (n == v);
            4'b1011: cond_pass = (n != v);
            4'b1100: cond_pass = ~z & (n == v);
            4'b1101: cond_pass = z | (n != v);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    endfunction

    // Contexts beyond NCTX exist only to pad the array to a power of two; they are never written.
    assign ctx_ok    = int'(bus.ctx_e) < NCTX;
    assign cur_flags = flags_q[bus.ctx_e];
    assign in_blk    = (state_q == ACTIVE) && (bus.ctx_e == blk_ctx_q);
    assign slot_cond = blk_then_q[slot_q] ? blk_cond_q : (blk_cond_q ^ 4'b0001);
    assign eff_cond  = in_blk ? slot_cond : bus.cond_e;
    assign live      = bus.valid_e & ~bus.flush_e;
    assign commit    = bus.cond_ex & ~bus.stall_e;
    assign consume   = in_blk & bus.valid_e & ~bus.stall_e & ~bus.flush_e;
    assign len_ok    = (bus.it_len != '0) && (int'(bus.it_len) <= MAXIT);

    assign bus.cond_ex    = live & ctx_ok & cond_pass(eff_cond, cur_flags);
    assign bus.undef_cond = live & (eff_cond == 4'b1111);
    assign bus.flags_e    = ctx_ok ? cur_flags : 4'b0000;
    assign bus.it_active  = (state_q == ACTIVE);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) flags_q[i] <= 4'b0000;
        end else if (commit) begin
            if (bus.flag_write_e[1]) flags_q[bus.ctx_e][3:2] <= bus.alu_flags[3:2];
            if (bus.flag_write_e[0]) flags_q[bus.ctx_e][1:0] <= bus.alu_flags[1:0];
        end
    end

    // Slots are consumed whether or not the instruction executes; flush abandons the block.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            blk_ctx_q  <= '0;
            blk_cond_q <= '0;
            blk_then_q <= '0;
            blk_len_q  <= '0;
            slot_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.it_start && len_ok) begin
                        state_q    <= ACTIVE;
                        blk_ctx_q  <= bus.it_ctx;
                        blk_cond_q <= bus.it_cond;
                        blk_then_q <= NSLOT'(bus.it_then);
                        blk_len_q  <= bus.it_len;
                        slot_q     <= '0;
                    end
                end
                ACTIVE: begin
                    if (bus.flush_e) begin
                        state_q <= IDLE;
                    end else if (consume) begin
                        if (slot_q == blk_len_q - LEN_ONE) state_q <= IDLE;
                        else slot_q <= slot_q + LEN_ONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cond_unit_mt.sv
// Directed bench for cond_unit_mt: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares them.
module tb_cond_unit_mt;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    cond_unit_mt_if #(.NCTX(2), .MAXIT(4)) bus ();

    cond_unit_mt #(.NCTX(2), .MAXIT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [3:0] mask;
        logic       cex;
        logic [3:0] flg;
        logic       act;
        logic       und;
        string      name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    localparam logic [3:0] M_ALL = 4'b1111;

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            if (mon_e.mask[3]) begin
                total++;
                if (bus.cond_ex !== mon_e.cex) begin
                    bad++;
                    $display("FAIL %s cond_ex got=%0b want=%0b", mon_e.name, bus.cond_ex, mon_e.cex);
                end
            end
            if (mon_e.mask[2]) begin
                total++;
                if (bus.flags_e !== mon_e.flg) begin
                    bad++;
                    $display("FAIL %s flags_e got=%b want=%b", mon_e.name, bus.flags_e, mon_e.flg);
                end
            end
            if (mon_e.mask[1]) begin
                total++;
                if (bus.it_active !== mon_e.act) begin
                    bad++;
                    $display("FAIL %s it_active got=%0b want=%0b", mon_e.name, bus.it_active, mon_e.act);
                end
            end
            if (mon_e.mask[0]) begin
                total++;
                if (bus.undef_cond !== mon_e.und) begin
                    bad++;
                    $display("FAIL %s undef_cond got=%0b want=%0b", mon_e.name, bus.undef_cond, mon_e.und);
                end
            end
        end
    end

    task automatic idle();
        bus.valid_e      = 1'b0;
        bus.stall_e      = 1'b0;
        bus.flush_e      = 1'b0;
        bus.ctx_e        = '0;
        bus.cond_e       = 4'b1110;
        bus.alu_flags    = 4'b0000;
        bus.flag_write_e = 2'b00;
        bus.it_start     = 1'b0;
        bus.it_ctx       = '0;
        bus.it_cond      = 4'b0000;
        bus.it_len       = '0;
        bus.it_then      = '0;
    endtask

    task automatic instr(input logic ctx, input logic [3:0] cond, input logic [3:0] alu,
                         input logic [1:0] fw);
        bus.valid_e      = 1'b1;
        bus.ctx_e        = ctx;
        bus.cond_e       = cond;
        bus.alu_flags    = alu;
        bus.flag_write_e = fw;
    endtask

    task automatic open_blk(input logic [3:0] cond, input logic [2:0] len, input logic [3:0] thn);
        bus.it_start = 1'b1;
        bus.it_ctx   = 1'b0;
        bus.it_cond  = cond;
        bus.it_len   = len;
        bus.it_then  = thn;
    endtask

    task automatic chk(input logic [3:0] m, input logic cex, input logic [3:0] flg,
                       input logic act, input logic und, input string nm);
        exp_t e;
        e.mask = m; e.cex = cex; e.flg = flg; e.act = act; e.und = und; e.name = nm;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        idle();                                     chk(M_ALL, 0, 4'b0000, 0, 0, "reset_state");
        // Flag write and same-cycle invisibility
        idle(); instr(0, 4'b1110, 4'b0100, 2'b11);  chk(M_ALL, 1, 4'b0000, 0, 0, "subs_ctx0");
        idle(); instr(0, 4'b0000, 4'b0000, 2'b00);  chk(M_ALL, 1, 4'b0100, 0, 0, "eq_ctx0");
        idle(); instr(1, 4'b0000, 4'b0000, 2'b00);  chk(M_ALL, 0, 4'b0000, 0, 0, "eq_ctx1");
        // NZ-only write on ctx1
        idle(); instr(1, 4'b1110, 4'b1111, 2'b10);  chk(M_ALL, 1, 4'b0000, 0, 0, "nz_write");
        idle(); instr(1, 4'b0010, 4'b0000, 2'b00);  chk(M_ALL, 0, 4'b1100, 0, 0, "nz_only_cs");
        // Block EQ,NE,EQ on ctx0 (Z=1), same-cycle instr uses cond_e NE
        idle(); open_blk(4'b0000, 3'd3, 4'b0101); instr(0, 4'b0001, 4'b0000, 2'b00);
                                                    chk(M_ALL, 0, 4'b0100, 0, 0, "it_same_cycle");
        idle(); instr(0, 4'b1110, 4'b0000, 2'b00);  chk(M_ALL, 1, 4'b0100, 1, 0, "slot0_then");
        idle(); instr(1, 4'b0000, 4'b0000, 2'b00);  chk(M_ALL, 1, 4'b1100, 1, 0, "ctx1_bypass");
        idle(); instr(0, 4'b1110, 4'b0000, 2'b00);  chk(M_ALL, 0, 4'b0100, 1, 0, "slot1_else");
        idle(); instr(0, 4'b1110, 4'b0000, 2'b00);  chk(M_ALL, 1, 4'b0100, 1, 0, "slot2_then");
        idle();                                     chk(4'b0010, 0, 4'b0000, 0, 0, "it_closed");
        // Stall holds commit and slot
        idle(); open_blk(4'b0000, 3'd2, 4'b0011);   chk(4'b0010, 0, 4'b0000, 0, 0, "stall_open");
        idle(); instr(0, 4'b1110, 4'b0000, 2'b11); bus.stall_e = 1'b1;
                                                    chk(M_ALL, 1, 4'b0100, 1, 0, "stall_c1");
        idle(); instr(0, 4'b1110, 4'b0000, 2'b11); bus.stall_e = 1'b1;
                                                    chk(M_ALL, 1, 4'b0100, 1, 0, "stall_c2");
        idle(); instr(0, 4'b1110, 4'b0000, 2'b11);  chk(M_ALL, 1, 4'b0100, 1, 0, "stall_release");
        idle(); instr(0, 4'b1110, 4'b0000, 2'b00);  chk(M_ALL, 0, 4'b0000, 1, 0, "slot1_after_stall");
        idle();                                     chk(4'b0010, 0, 4'b0000, 0, 0, "stall_blk_closed");
        // Flush mid-block (stall also high: flush wins)
        idle(); instr(0, 4'b1110, 4'b0100, 2'b11);  chk(M_ALL, 1, 4'b0000, 0, 0, "set_z");
        idle(); open_blk(4'b0000, 3'd3, 4'b0111);   chk(4'b0010, 0, 4'b0000, 0, 0, "flush_open");
        idle(); instr(0, 4'b1110, 4'b0000, 2'b00);  chk(M_ALL, 1, 4'b0100, 1, 0, "flush_slot0");
        idle(); instr(0, 4'b1110, 4'b0000, 2'b11); bus.flush_e = 1'b1; bus.stall_e = 1'b1;
                                                    chk(M_ALL, 0, 4'b0100, 1, 0, "flush_cycle");
        idle();                                     chk(M_ALL, 0, 4'b0100, 0, 0, "after_flush");
        // Undefined condition, direct and via else-slot of AL
        idle(); instr(0, 4'b1111, 4'b0000, 2'b11);  chk(M_ALL, 0, 4'b0100, 0, 1, "undef_direct");
        idle(); bus.cond_e = 4'b1111;               chk(M_ALL, 0, 4'b0100, 0, 0, "undef_nowrite");
        idle(); bus.it_len = 3'd5; bus.it_start = 1'b1;
                                                    chk(4'b0010, 0, 4'b0000, 0, 0, "len_too_big");
        idle();                                     chk(4'b0010, 0, 4'b0000, 0, 0, "len_ignored");
        idle(); open_blk(4'b1110, 3'd1, 4'b0000);   chk(4'b0010, 0, 4'b0000, 0, 0, "al_open");
        idle(); instr(0, 4'b1110, 4'b0000, 2'b11);  chk(M_ALL, 0, 4'b0100, 1, 1, "al_else_undef");
        idle();                                     chk(M_ALL, 0, 4'b0100, 0, 0, "al_blk_closed");
        // Reset while a block is open
        idle(); open_blk(4'b0000, 3'd4, 4'b1111);   chk(4'b0010, 0, 4'b0000, 0, 0, "rst_open");
        idle(); instr(0, 4'b1110, 4'b0000, 2'b00);  chk(M_ALL, 1, 4'b0100, 1, 0, "rst_slot0");
        idle(); bus.ctx_e = 1'b1; reset = 1'b1;     chk(4'b0110, 0, 4'b1100, 1, 0, "rst_asserted");
        reset = 1'b0;
        idle();                                     chk(M_ALL, 0, 4'b0000, 0, 0, "rst_ctx0");
        idle(); bus.ctx_e = 1'b1;                   chk(4'b0100, 0, 4'b0000, 0, 0, "rst_ctx1");

        @(negedge clk);
        #1;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain left=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cond_unit_mt.md
COND_UNIT_MT -- requirements
Module: cond_unit_mt

Interface
REQ-001 SHALL have parameter NCTX, default 2: number of independent NZCV flag contexts, 1..8.
REQ-002 SHALL have parameter MAXIT, default 4: maximum predicated-block length, 1..4.
REQ-003 SHALL derive local CTXW = max(1, clog2(NCTX)) and LENW = clog2(MAXIT+1).
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 valid_e  in  1  Execute-stage instruction present.
REQ-007 stall_e  in  1  Execute stage held this cycle.
REQ-008 flush_e  in  1  Execute instruction squashed this cycle.
REQ-009 ctx_e  in  CTXW  flag context of the Execute instruction.
REQ-010 cond_e  in  4  ARM condition field of the instruction.
REQ-011 alu_flags  in  4  ALU result flags {N,Z,C,V}.
REQ-012 flag_write_e  in  2  bit1 = write N,Z; bit0 = write C,V.
REQ-013 it_start  in  1  request to open a predicated block.
REQ-014 it_ctx  in  CTXW  context the block applies to.
REQ-015 it_cond  in  4  base condition of the block.
REQ-016 it_len  in  LENW  block length in instructions, 1..MAXIT.
REQ-017 it_then  in  MAXIT  per slot: 1 = it_cond, 0 = inverse (it_cond ^ 4'b0001).
REQ-018 cond_ex  out  1  instruction executes.
REQ-019 flags_e  out  4  committed flags of context ctx_e.
REQ-020 it_active  out  1  predicated block open.
REQ-021 undef_cond  out  1  valid instruction evaluated an undefined condition.

Function
REQ-022 SHALL hold one 4-bit flag register per context, split into NZ and CV halves.
REQ-023 SHALL evaluate the effective condition combinationally against flags[ctx_e] with standard ARM EQ..AL encodings 0000..1110.
REQ-024 Effective condition SHALL be the current IT slot condition when it_active is 1 and ctx_e equals the latched block context; otherwise it SHALL be cond_e.
REQ-025 Effective condition 1111 SHALL force cond_ex to 0; undef_cond SHALL then be 1 if valid_e=1 and flush_e=0.
REQ-026 cond_ex SHALL be valid_e & ~flush_e & (ctx_e < NCTX) & pass; during stall it SHALL still be reported.
REQ-027 A commit SHALL be valid_e & ~stall_e & ~flush_e & cond_ex.
REQ-028 On commit, flags[ctx_e][3:2] SHALL load alu_flags[3:2] if flag_write_e[1]; flags[ctx_e][1:0] SHALL load alu_flags[1:0] if flag_write_e[0].
REQ-029 A new flag value SHALL be visible on flags_e and used by the condition check from the next cycle; there SHALL be no same-cycle bypass.
REQ-030 SHALL implement the IT sequencer FSM with states IDLE and ACTIVE, holding latched ctx, cond, then-mask, length, and a slot counter.
REQ-031 IDLE->ACTIVE SHALL occur when it_start=1 and it_len is 1..MAXIT, with the slot counter set to 0; it_len 0 or >MAXIT SHALL be ignored.
REQ-032 In ACTIVE, each cycle that is valid, not stalled, not flushed and matches the block context SHALL consume one slot, executed or not.
REQ-033 ACTIVE->IDLE SHALL occur when the last slot (it_len-1) is consumed, or on flush_e=1.
REQ-034 it_start SHALL be ignored while ACTIVE.
REQ-035 An instruction present in the same cycle as it_start SHALL use cond_e and SHALL NOT consume a slot.
REQ-036 Instructions of other contexts SHALL bypass the block and leave the slot counter unchanged.
REQ-037 An else slot with it_cond=1110 SHALL yield 1111, i.e. undefined per REQ-025.
REQ-038 Flush and stall asserted together SHALL act as flush.

Reset
REQ-039 Reset SHALL clear all flag contexts to 0000, force the FSM to IDLE, and clear the counter and latched block fields; it SHALL take priority over all other inputs.
REQ-040 After reset: it_active=0, flags_e=0000, undef_cond=0 unless REQ-025 applies, and cond_ex follows REQ-026 on zero flags.

Verification
REQ-041 reset; ctx0 SUBS-like: valid, cond_e=1110, alu_flags=0100, flag_write_e=11 -> next cycle flags_e(ctx0)=0100; EQ instruction on ctx0 gives cond_ex=1; EQ on ctx1 gives cond_ex=0.
REQ-042 flag_write_e=10 with alu_flags=1111 on flags 0000 -> flags become 1100; C,V unchanged.
REQ-043 it_start, it_ctx=0, it_cond=0000, it_len=3, it_then=101, with Z=1 -> three ctx0 instructions give cond_ex 1,0,1; it_active falls after the third; an interleaved ctx1 instruction does not consume a slot.
REQ-044 stall_e=1 with a flag-writing instruction for 2 cycles -> flags unchanged and slot not consumed; commit happens on the first unstalled cycle.
REQ-045 flush_e=1 mid-block after slot 1 -> cond_ex=0, no flag write, it_active=0 next cycle.
REQ-046 cond_e=1111 valid -> cond_ex=0, undef_cond=1, no flag write; synchronous reset during ACTIVE -> it_active=0 and all flags 0000 next cycle.
